// File: rtl/pattern_runner_pkg.sv
// pattern_runner_pkg: shared FSM state type and helpers for pattern_runner.
//   state_t    : run-controller states
//   misr_step  : rotate-left-by-one then XOR, over the low w bits of a 64-bit word
//   clamp_npat : limits the requested pattern count to the memory depth
package pattern_runner_pkg;

    typedef enum logic [2:0] {IDLE, APPLY, WAIT, CAPTURE, DONE} state_t;

    function automatic logic [63:0] misr_step(input logic [63:0] sig, input logic [63:0] din, input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return (((sig << 1) | (sig >> (w - 1))) & mask) ^ (din & mask);
    endfunction

    function automatic int clamp_npat(input int n, input int depth);
        return (n > depth) ? depth : n;
    endfunction

endpackage

// File: rtl/pattern_runner_mem.sv
// pattern_runner_mem: DEPTH x W pattern store, one write port, one async read port, not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write slot
//   wdata : write word {stim, gold}
//   raddr : read slot
//   rdata : read word, write-first when waddr==raddr during a write
module pattern_runner_mem #(
    parameter int DEPTH = 8,
    parameter int W = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = (we && waddr == raddr) ? wdata : mem[raddr];

endmodule

// File: rtl/pattern_runner.sv
// pattern_runner: applies stored stimuli to a combinational CUT, captures and checks each response.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ld_valid/ld_ready   : pattern load handshake (ready only in IDLE)
//   ld_addr/stim/gold   : slot, stimulus and expected response to load
//   start, num_pat      : run request and pattern count, sampled in IDLE
//   busy, done          : run in progress, one-cycle end-of-run pulse
//   cut_in, cut_out     : registered CUT drive, CUT response
//   resp_valid/idx/data/fail : per-pattern captured response stream
//   mismatch_cnt        : saturating failure count for the current run
//   first_fail_vld/idx  : first failing pattern of the current run
//   signature           : MISR over {cut_in, cut_out}, only with PATTERN_RUNNER_MISR_EN
module pattern_runner
    import pattern_runner_pkg::*;
#(
    parameter int IN_W = 5,
    parameter int OUT_W = 3,
    parameter int DEPTH = 8,
    parameter int SETTLE = 1,
    parameter int CNT_W = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int NW = AW + 1,
    localparam int MW = IN_W + OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [AW-1:0]    ld_addr,
    input  logic [IN_W-1:0]  ld_stim,
    input  logic [OUT_W-1:0] ld_gold,
    input  logic             start,
    input  logic [NW-1:0]    num_pat,
    output logic             busy,
    output logic             done,
    output logic [IN_W-1:0]  cut_in,
    input  logic [OUT_W-1:0] cut_out,
    output logic             resp_valid,
    output logic [AW-1:0]    resp_idx,
    output logic [OUT_W-1:0] resp_data,
    output logic             resp_fail,
    output logic [CNT_W-1:0] mismatch_cnt,
`ifdef PATTERN_RUNNER_MISR_EN
    output logic [MW-1:0]    signature,
`endif
    output logic             first_fail_vld,
    output logic [AW-1:0]    first_fail_idx
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t         state, next_state;
    logic [AW-1:0]  idx;
    logic [NW-1:0]  npat;
    logic [SW-1:0]  scnt;
    logic [MW-1:0]  rdata;
    logic [IN_W-1:0] stim;
    logic [OUT_W-1:0] gold;
    logic           we, last, fail;

    assign we   = ld_valid && ld_ready;
    assign stim = rdata[MW-1:OUT_W];
    assign gold = rdata[OUT_W-1:0];
    assign last = {1'b0, idx} == npat - NW'(1);
    assign fail = cut_out != gold;

    pattern_runner_mem #(.DEPTH(DEPTH), .W(MW)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (ld_addr),
        .wdata ({ld_stim, ld_gold}),
        .raddr (idx),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next_state;

    always_comb begin
        next_state = state;
        ld_ready = state == IDLE;
        busy = state != IDLE;
        done = state == DONE;
        case (state)
            IDLE:    next_state = start ? ((num_pat == '0) ? DONE : APPLY) : IDLE;
            APPLY:   next_state = WAIT;
            WAIT:    next_state = (scnt == '0) ? CAPTURE : WAIT;
            CAPTURE: next_state = last ? DONE : APPLY;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx <= '0;
            npat <= '0;
            scnt <= '0;
            cut_in <= '0;
            resp_valid <= 1'b0;
            resp_idx <= '0;
            resp_data <= '0;
            resp_fail <= 1'b0;
            mismatch_cnt <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
`ifdef PATTERN_RUNNER_MISR_EN
            signature <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    npat <= NW'(clamp_npat(int'(num_pat), DEPTH));
                    idx <= '0;
                    mismatch_cnt <= '0;
                    first_fail_vld <= 1'b0;
                    first_fail_idx <= '0;
`ifdef PATTERN_RUNNER_MISR_EN
                    signature <= '0;
`endif
                end
                APPLY: begin
                    cut_in <= stim;
                    scnt <= SW'(SETTLE - 1);
                end
                WAIT: if (scnt != '0) scnt <= scnt - SW'(1);
                CAPTURE: begin
                    resp_valid <= 1'b1;
                    resp_idx <= idx;
                    resp_data <= cut_out;
                    resp_fail <= fail;
                    if (fail && mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                    if (fail && !first_fail_vld) begin
                        first_fail_vld <= 1'b1;
                        first_fail_idx <= idx;
                    end
                    idx <= idx + AW'(1);
`ifdef PATTERN_RUNNER_MISR_EN
                    signature <= MW'(misr_step(64'(signature), 64'({cut_in, cut_out}), MW));
`endif
                end
                default: ;
            endcase
        end

endmodule

// File: tb/tb_pattern_runner.sv
// tb_pattern_runner: directed self-checking bench for pattern_runner (default and CNT_W=2 instances).
module tb_pattern_runner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld_valid = 1'b0;
    logic       ld_ready, ld_ready2;
    logic [2:0] ld_addr = '0;
    logic [4:0] ld_stim = '0;
    logic [2:0] ld_gold = '0;
    logic       start = 1'b0;
    logic [3:0] num_pat = '0;
    logic       busy, done, busy2, done2;
    logic [4:0] cut_in, cut_in2;
    logic [2:0] cut_out, cut_out2;
    logic       resp_valid, resp_fail, resp_valid2, resp_fail2;
    logic [2:0] resp_idx, resp_idx2;
    logic [2:0] resp_data, resp_data2;
    logic [7:0] mismatch_cnt;
    logic [1:0] mismatch_cnt2;
    logic       first_fail_vld, first_fail_vld2;
    logic [2:0] first_fail_idx, first_fail_idx2;
`ifdef PATTERN_RUNNER_MISR_EN
    logic [7:0] signature, signature2;
`endif

    int passed = 0;
    int total = 0;

    int nresp, first_resp, done_cyc, done_cnt;
    bit ldr_busy;
    int r_idx[16];
    int r_data[16];
    int r_fail[16];
    logic [4:0] stim_tab[8];

    assign cut_out = cut_in[2:0];
    assign cut_out2 = cut_in2[2:0];

    always #5 clk = ~clk;

    pattern_runner dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_stim(ld_stim), .ld_gold(ld_gold), .start(start), .num_pat(num_pat), .busy(busy),
        .done(done), .cut_in(cut_in), .cut_out(cut_out), .resp_valid(resp_valid),
        .resp_idx(resp_idx), .resp_data(resp_data), .resp_fail(resp_fail),
        .mismatch_cnt(mismatch_cnt),
`ifdef PATTERN_RUNNER_MISR_EN
        .signature(signature),
`endif
        .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx)
    );

    pattern_runner #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready2), .ld_addr(ld_addr),
        .ld_stim(ld_stim), .ld_gold(ld_gold), .start(start), .num_pat(num_pat), .busy(busy2),
        .done(done2), .cut_in(cut_in2), .cut_out(cut_out2), .resp_valid(resp_valid2),
        .resp_idx(resp_idx2), .resp_data(resp_data2), .resp_fail(resp_fail2),
        .mismatch_cnt(mismatch_cnt2),
`ifdef PATTERN_RUNNER_MISR_EN
        .signature(signature2),
`endif
        .first_fail_vld(first_fail_vld2), .first_fail_idx(first_fail_idx2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else passed++;
    endtask

    task automatic load(input int addr, input logic [4:0] s, input logic [2:0] g);
        ld_valid = 1'b1;
        ld_addr = 3'(addr);
        ld_stim = s;
        ld_gold = g;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
    endtask

    // Cycle c is the cycle following the c-th rising edge after start was driven.
    task automatic run(input int np, input bit disturb, input int abort_at);
        nresp = 0;
        first_resp = -1;
        done_cyc = -1;
        done_cnt = 0;
        ldr_busy = 0;
        num_pat = 4'(np);
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            ld_valid = 1'b0;
            if (resp_valid) begin
                if (first_resp < 0) first_resp = c;
                if (nresp < 16) begin
                    r_idx[nresp] = int'(resp_idx);
                    r_data[nresp] = int'(resp_data);
                    r_fail[nresp] = int'(resp_fail);
                end
                nresp++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (busy && ld_ready) ldr_busy = 1;
            if (abort_at == c) break;
            if (disturb && c == 2) begin
                start = 1'b1;
                num_pat = 4'd1;
                ld_valid = 1'b1;
                ld_addr = 3'd0;
                ld_stim = 5'b11111;
                ld_gold = 3'b111;
            end
            if (done_cyc > 0 && c >= done_cyc + 2) break;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) stim_tab[i] = 5'(i * 5 + 3);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_cut_in", cut_in, 0);
        check("rst_mismatch", mismatch_cnt, 0);
        check("rst_ffvld", first_fail_vld, 0);
`ifdef PATTERN_RUNNER_MISR_EN
        check("rst_signature", signature, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ld_ready", ld_ready, 1);

        load(0, 5'b00101, 3'b101);
        load(1, 5'b01010, 3'b010);
        load(2, 5'b10011, 3'b011);
        load(3, 5'b11100, 3'b100);
        run(4, 0, 0);
        check("a_nresp", nresp, 4);
        check("a_first_resp_cyc", first_resp, 4);
        check("a_done_cyc", done_cyc, 13);
        check("a_done_width", done_cnt, 1);
        check("a_idx3", r_idx[3], 3);
        check("a_data0", r_data[0], 3'b101);
        check("a_data2", r_data[2], 3'b011);
        check("a_fails", r_fail[0] + r_fail[1] + r_fail[2] + r_fail[3], 0);
        check("a_mismatch", mismatch_cnt, 0);
        check("a_ffvld", first_fail_vld, 0);
        check("a_cut_in_hold", cut_in, 5'b11100);

        // Slot 2 gold rewritten in the same cycle the run is started.
        ld_valid = 1'b1;
        ld_addr = 3'd2;
        ld_stim = 5'b10011;
        ld_gold = 3'b000;
        run(4, 0, 0);
        check("b_nresp", nresp, 4);
        check("b_fail_idx2", r_fail[2], 1);
        check("b_fails_other", r_fail[0] + r_fail[1] + r_fail[3], 0);
        check("b_mismatch", mismatch_cnt, 1);
        check("b_ffvld", first_fail_vld, 1);
        check("b_ffidx", first_fail_idx, 2);

        run(0, 0, 0);
        check("c_done_cyc", done_cyc, 1);
        check("c_nresp", nresp, 0);
        check("c_mismatch", mismatch_cnt, 0);
        check("c_ffvld", first_fail_vld, 0);

        for (int i = 0; i < 8; i++) load(i, stim_tab[i], ~stim_tab[i][2:0]);
        run(12, 0, 0);
        check("d_nresp", nresp, 8);
        check("d_idx7", r_idx[7], 7);
        check("d_data5", r_data[5], 3'(stim_tab[5]));
        check("d_fails", r_fail[0] + r_fail[3] + r_fail[7], 3);
        check("d_done_cyc", done_cyc, 25);
        check("d_mismatch", mismatch_cnt, 8);
        check("d_mismatch_sat", mismatch_cnt2, 3);
        check("d_ffidx", first_fail_idx2, 0);
        check("d_ffvld", first_fail_vld2, 1);

        run(4, 0, 5);
        check("e_pre_mismatch", mismatch_cnt, 1);
        check("e_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("e_busy", busy, 0);
        check("e_resp_valid", resp_valid, 0);
        check("e_mismatch", mismatch_cnt, 0);
        check("e_ffvld", first_fail_vld, 0);
        check("e_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        check("e_done_held", done, 0);
        rst_n = 1'b1;
        run(2, 0, 0);
        check("e_restart_nresp", nresp, 2);
        check("e_restart_data1", r_data[1], 3'(stim_tab[1]));
        check("e_restart_mismatch", mismatch_cnt, 2);
        check("e_restart_done", done_cyc, 7);

        run(3, 1, 0);
        check("f_nresp", nresp, 3);
        check("f_done_cyc", done_cyc, 10);
        check("f_done_width", done_cnt, 1);
        check("f_ld_ready_busy", ldr_busy, 0);
        run(1, 0, 0);
        check("f_mem_kept_mismatch", mismatch_cnt, 1);
        check("f_mem_kept_data", r_data[0], 3'(stim_tab[0]));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
